// File: rtl/nn_neuron_mac.sv
// nn_neuron_mac - streaming neuron engine: out = sat((bias << FRAC_W + sum(act*wgt)) >>> FRAC_W)
//
// Ports:
//   clk_i, reset_i        clock (rising edge), asynchronous active-low reset
//   start_i               begin an operation (sampled only while idle)
//   beat_count_i, bias_i  beats in this operation and signed bias, latched with start_i
//   busy_o                high whenever an operation is in progress
//   in_valid_i/in_ready_o input beat handshake; act_i/wgt_i carry LANES packed pairs
//   out_valid_o/out_ready_i result handshake; out_data_o is the saturated result
//   done_o                high in the cycle the result is handed over
//
// Optional build macro: NN_NEURON_RELU_EN - clamps negative results to zero.
module nn_neuron_mac #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int LANES  = 1,
  parameter int CNT_W  = 16,
  parameter int ACC_W  = 48
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    start_i,
  input  logic [CNT_W-1:0]        beat_count_i,
  input  logic [DATA_W-1:0]       bias_i,
  output logic                    busy_o,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [LANES*DATA_W-1:0] act_i,
  input  logic [LANES*DATA_W-1:0] wgt_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [DATA_W-1:0]       out_data_o,
  output logic                    done_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_FINISH = 2'd2,
    ST_OUTPUT = 2'd3
  } state_e;

  // Signed DATA_W range limits, sign-extended to accumulator width.
  localparam logic signed [ACC_W-1:0] SAT_MAX = $signed({{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] SAT_MIN = $signed({{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}});
  localparam logic [CNT_W-1:0]        CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                busy_q, in_ready_q, out_valid_q;
  logic [ACC_W-1:0]    beat_sum;

  // Signed product of one lane, sign-extended to accumulator width. Operands are
  // widened first so the multiply is full precision at 2*DATA_W bits.
  function automatic logic [ACC_W-1:0] lane_prod(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic signed [2*DATA_W-1:0] a_x;
    logic signed [2*DATA_W-1:0] b_x;
    logic signed [2*DATA_W-1:0] p;
    a_x = $signed({{DATA_W{a[DATA_W-1]}}, a});
    b_x = $signed({{DATA_W{b[DATA_W-1]}}, b});
    p   = a_x * b_x;
    return {{(ACC_W-2*DATA_W){p[2*DATA_W-1]}}, p};
  endfunction

  // Drop fractional bits (floor), clamp to DATA_W signed range, optional ReLU.
  function automatic logic [DATA_W-1:0] sat_shift(input logic [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] sh;
    logic [DATA_W-1:0]       r;
    sh = $signed(acc) >>> FRAC_W;
    if (sh > SAT_MAX) begin
      r = SAT_MAX[DATA_W-1:0];
    end else if (sh < SAT_MIN) begin
      r = SAT_MIN[DATA_W-1:0];
    end else begin
      r = sh[DATA_W-1:0];
    end
`ifdef NN_NEURON_RELU_EN
    if (r[DATA_W-1]) begin
      r = {DATA_W{1'b0}};
    end else begin
      r = r;
    end
`else
    r = r;
`endif
    return r;
  endfunction

  // Sum of all lane products of the current input beat.
  always_comb begin
    beat_sum = {ACC_W{1'b0}};
    for (int k = 0; k < LANES; k++) begin
      beat_sum = beat_sum + lane_prod(act_i[k*DATA_W +: DATA_W], wgt_i[k*DATA_W +: DATA_W]);
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    out_data_d = out_data_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          rem_d = beat_count_i;
          acc_d = {{(ACC_W-DATA_W){bias_i[DATA_W-1]}}, bias_i} << FRAC_W;
          if (beat_count_i != {CNT_W{1'b0}}) begin
            state_d = ST_ACCUM;
          end else begin
            state_d = ST_FINISH;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (in_valid_i && in_ready_q) begin
          acc_d = acc_q + beat_sum;
          rem_d = rem_q - CNT_ONE;
          if (rem_q == CNT_ONE) begin
            state_d = ST_FINISH;
          end else begin
            state_d = ST_ACCUM;
          end
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_FINISH: begin
        out_data_d = sat_shift(acc_q);
        state_d    = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        if (out_ready_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_OUTPUT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and status flops; status flags are decoded from the next state
  // so they are glitch-free registered copies of the current state.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= ST_IDLE;
      acc_q       <= {ACC_W{1'b0}};
      rem_q       <= {CNT_W{1'b0}};
      out_data_q  <= {DATA_W{1'b0}};
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      out_data_q  <= out_data_d;
      busy_q      <= (state_d != ST_IDLE);
      in_ready_q  <= (state_d == ST_ACCUM);
      out_valid_q <= (state_d == ST_OUTPUT);
    end
  end

  assign busy_o      = busy_q;
  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  // Must be high in the handshake cycle itself, so it cannot be registered.
  assign done_o      = out_valid_q & out_ready_i;

endmodule

// File: tb/tb_nn_neuron_mac.sv
// Self-checking bench for nn_neuron_mac: directed plan cases plus random operations,
// compared against an integer reference model of the neuron equation.
module tb_nn_neuron_mac;

  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic        start_i = 1'b0;
  logic [15:0] beat_count_i = 16'd0;
  logic [15:0] bias_i = 16'd0;
  logic        busy_o, in_ready_o, out_valid_o, done_o;
  logic        in_valid_i = 1'b0;
  logic [15:0] act_i = 16'd0, wgt_i = 16'd0;
  logic        out_ready_i = 1'b0;
  logic [15:0] out_data_o;

  // four-lane instance
  logic        start4 = 1'b0;
  logic [15:0] cnt4 = 16'd0, bias4 = 16'd0;
  logic        busy4, rdy4, ovld4, done4;
  logic        vld4 = 1'b0;
  logic [63:0] act4 = 64'd0, wgt4 = 64'd0;
  logic        ordy4 = 1'b0;
  logic [15:0] data4;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] act_q[$];
  logic [15:0] wgt_q[$];

  always #5 clk = ~clk;

  nn_neuron_mac u_dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .beat_count_i(beat_count_i),
    .bias_i(bias_i), .busy_o(busy_o), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .act_i(act_i), .wgt_i(wgt_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .done_o(done_o)
  );

  nn_neuron_mac #(.LANES(4)) u_dut4 (
    .clk_i(clk), .reset_i(reset_i), .start_i(start4), .beat_count_i(cnt4),
    .bias_i(bias4), .busy_o(busy4), .in_valid_i(vld4), .in_ready_o(rdy4),
    .act_i(act4), .wgt_i(wgt4), .out_valid_o(ovld4), .out_ready_i(ordy4),
    .out_data_o(data4), .done_o(done4)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: exact integer dot product, floor division by 2^8, clamp, optional ReLU.
  function automatic logic [15:0] ref_result(input logic [15:0] bias);
    longint s;
    longint r;
    s = longint'($signed(bias)) * 256;
    for (int i = 0; i < act_q.size(); i++)
      s += longint'($signed(act_q[i])) * longint'($signed(wgt_q[i]));
    r = s >>> 8;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
`ifdef NN_NEURON_RELU_EN
    if (r < 0) r = 0;
`endif
    return 16'(r);
  endfunction

  // One full operation on the single-lane instance using the beats in act_q/wgt_q.
  task automatic run_op(input string tag, input logic [15:0] bias, input int gap_pct,
                        input int hold, input bit poke);
    int          count, idx, budget;
    bit          acc, saw_ready;
    logic [15:0] exp;
    count = act_q.size();
    exp   = ref_result(bias);
    @(posedge clk); #1;
    start_i = 1'b1; bias_i = bias; beat_count_i = 16'(count);
    @(posedge clk); #1;
    start_i = 1'b0;
    check_eq({tag, "_busy"}, busy_o, 1'b1);
    idx = 0; budget = 0; saw_ready = 1'b0;
    while (idx < count && budget < 500) begin
      in_valid_i = ($urandom_range(99) >= gap_pct);
      act_i = act_q[idx]; wgt_i = wgt_q[idx];
      if (poke && budget == 0) begin
        start_i = 1'b1; bias_i = 16'h7000; beat_count_i = 16'd1;
      end
      @(negedge clk);
      acc = in_valid_i && in_ready_o;
      @(posedge clk); #1;
      start_i = 1'b0;
      if (acc) idx++;
      budget++;
    end
    in_valid_i = 1'b0;
    check_eq({tag, "_beats"}, idx, count);
    // first cycle after the last accepting (or start) edge: FINISH
    check_eq({tag, "_fin_vld"}, out_valid_o, 1'b0);
    if (count == 0) check_eq({tag, "_no_rdy"}, in_ready_o, 1'b0);
    @(posedge clk); #1;
    check_eq({tag, "_vld"}, out_valid_o, 1'b1);
    check_eq({tag, "_data"}, out_data_o, exp);
    for (int h = 0; h < hold; h++) begin
      if (h == 1) start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      check_eq({tag, "_hold_vld"}, out_valid_o, 1'b1);
      check_eq({tag, "_hold_data"}, out_data_o, exp);
      check_eq({tag, "_hold_done"}, done_o, 1'b0);
    end
    out_ready_i = 1'b1; #1;
    check_eq({tag, "_done"}, done_o, 1'b1);
    @(posedge clk); #1;
    out_ready_i = 1'b0;
    check_eq({tag, "_post_vld"}, out_valid_o, 1'b0);
    check_eq({tag, "_post_done"}, done_o, 1'b0);
    check_eq({tag, "_post_busy"}, busy_o, 1'b0);
    check_eq({tag, "_keep"}, out_data_o, exp);
    @(posedge clk); #1;
    check_eq({tag, "_idle_busy"}, busy_o, 1'b0);
  endtask

  task automatic set_beats(input logic [15:0] a[], input logic [15:0] w[]);
    act_q.delete(); wgt_q.delete();
    foreach (a[i]) begin act_q.push_back(a[i]); wgt_q.push_back(w[i]); end
  endtask

  initial begin
    logic [15:0] exp4;
    int          wait_cnt;
    // reset state
    #12;
    check_eq("rst_busy", busy_o, 1'b0);
    check_eq("rst_rdy", in_ready_o, 1'b0);
    check_eq("rst_vld", out_valid_o, 1'b0);
    check_eq("rst_done", done_o, 1'b0);
    check_eq("rst_data", out_data_o, 16'h0000);
    reset_i = 1'b1;

    set_beats('{16'h0100, 16'h0080, 16'hFF00}, '{16'h0200, 16'h0080, 16'h0100});
    run_op("t1", 16'h0000, 0, 0, 1'b0);
    set_beats('{}, '{});
    run_op("t2_zero", 16'h0300, 0, 0, 1'b0);
    set_beats('{16'h7FFF}, '{16'h7FFF});
    run_op("t3_pos", 16'h0000, 0, 0, 1'b0);
    set_beats('{16'h7FFF}, '{16'h8000});
    run_op("t3_neg", 16'h0000, 0, 0, 1'b0);
    set_beats('{16'h0000}, '{16'h0000});
    run_op("t3_bias", 16'hFF80, 0, 0, 1'b0);
    set_beats('{16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100},
              '{16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100});
    run_op("t4_gaps", 16'h0000, 40, 5, 1'b1);

    // random operations
    for (int n = 0; n < 12; n++) begin
      act_q.delete(); wgt_q.delete();
      for (int b = 0; b < int'($urandom_range(6)); b++) begin
        act_q.push_back(16'($urandom)); wgt_q.push_back(16'($urandom_range(1023)) - 16'd512);
      end
      run_op($sformatf("rnd%0d", n), 16'($urandom), 30, int'($urandom_range(3)), n[0]);
    end

    // reset in the middle of accumulation
    @(posedge clk); #1;
    start_i = 1'b1; bias_i = 16'h0500; beat_count_i = 16'd4;
    @(posedge clk); #1;
    start_i = 1'b0; in_valid_i = 1'b1; act_i = 16'h0100; wgt_i = 16'h0300;
    repeat (2) @(posedge clk);
    #1; reset_i = 1'b0; in_valid_i = 1'b0; #1;
    check_eq("t5_busy", busy_o, 1'b0);
    check_eq("t5_rdy", in_ready_o, 1'b0);
    check_eq("t5_vld", out_valid_o, 1'b0);
    check_eq("t5_done", done_o, 1'b0);
    check_eq("t5_data", out_data_o, 16'h0000);
    @(posedge clk); #1; reset_i = 1'b1;
    set_beats('{16'h0200}, '{16'h0200});
    run_op("t5_fresh", 16'h0000, 0, 0, 1'b0);

    // four lanes
    act_q.delete(); wgt_q.delete();
    for (int i = 0; i < 8; i++) begin act_q.push_back(16'h0100); wgt_q.push_back(16'h0100); end
    exp4 = ref_result(16'h0100);
    @(posedge clk); #1;
    start4 = 1'b1; bias4 = 16'h0100; cnt4 = 16'd2;
    @(posedge clk); #1;
    start4 = 1'b0; vld4 = 1'b1; act4 = {4{16'h0100}}; wgt4 = {4{16'h0100}};
    check_eq("t6_rdy", rdy4, 1'b1);
    repeat (2) @(posedge clk);
    #1; vld4 = 1'b0;
    wait_cnt = 0;
    while (!ovld4 && wait_cnt < 20) begin @(posedge clk); #1; wait_cnt++; end
    check_eq("t6_lat", wait_cnt, 1);
    check_eq("t6_data", data4, exp4);
    ordy4 = 1'b1; #1;
    check_eq("t6_done", done4, 1'b1);
    @(posedge clk); #1; ordy4 = 1'b0;
    check_eq("t6_busy", busy4, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
